// File: rtl/l1d_package.sv
// Shared L1D types and sizing: the evict read beat, the completion record and the line geometry.
package l1d_package;

    localparam int CREDIT_BUF_DEPTH  = 4;
    localparam int L1D_MSHR_ID_WIDTH = 4;
    localparam int L1D_OFFSET_NUM    = 2;
    localparam int L1D_OFFSET_WIDTH  = (L1D_OFFSET_NUM > 1) ? $clog2(L1D_OFFSET_NUM) : 1;
    localparam int L1D_TAG_WIDTH     = 20;
    localparam int L1D_INDEX_WIDTH   = 6;
    localparam int L1D_DATA_WIDTH    = 256;

    typedef struct packed {
        logic [L1D_TAG_WIDTH-1:0]     tag;
        logic [L1D_INDEX_WIDTH-1:0]   index;
        logic [L1D_OFFSET_WIDTH-1:0]  offset;
        logic [L1D_DATA_WIDTH-1:0]    data;
        logic                         rd_last;
        logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
    } pack_l1d_data_ram_evict_req;

    typedef struct packed {
        logic [L1D_MSHR_ID_WIDTH-1:0] evict_id;
    } pack_l1d_evict_done;

    function automatic logic is_last_offset(input logic [L1D_OFFSET_WIDTH-1:0] off);
        return off == L1D_OFFSET_WIDTH'(L1D_OFFSET_NUM - 1);
    endfunction

endpackage

// File: rtl/l1d_evict_buf_if.sv
// Evict buffer bus: evict beats in, write-back beats out, credit/done/error status back.
interface l1d_evict_buf_if;
    import l1d_package::*;

    logic                         evict_vld;
    pack_l1d_data_ram_evict_req   evict_pld;
    logic                         credit_ret;
    logic                         wb_vld;
    logic                         wb_rdy;
    pack_l1d_data_ram_evict_req   wb_pld;
    logic                         evict_done_vld;
    logic [L1D_MSHR_ID_WIDTH-1:0] evict_done_id;
    logic                         err_overflow;
    logic                         err_seq;

    // slave is the evict buffer itself; master is the surrounding pipe, write-back channel and MSHR
    modport slave (
        input  evict_vld, evict_pld, wb_rdy,
        output credit_ret, wb_vld, wb_pld, evict_done_vld, evict_done_id, err_overflow, err_seq
    );

    modport master (
        output evict_vld, evict_pld, wb_rdy,
        input  credit_ret, wb_vld, wb_pld, evict_done_vld, evict_done_id, err_overflow, err_seq
    );

endinterface

// File: rtl/l1d_evict_fifo.sv
// Generic circular pointer FIFO; pointers carry a wrap bit so full/empty need no counter.
module l1d_evict_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) && (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a beat when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q[IDX_W-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[IDX_W-1:0]] = din;
            wptr_d                   = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/l1d_evict_buf.sv
// L1D write-back staging buffer: credit-returning FIFO with line-done reporting and sequence checks.
// Optional L1D_EVICT_BUF_BYPASS_EN: an empty buffer forwards the incoming beat straight to wb.
module l1d_evict_buf
    import l1d_package::*;
#(
    parameter int BUF_DEPTH = CREDIT_BUF_DEPTH,
    parameter int PTR_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    l1d_evict_buf_if.slave bus
);

    localparam int PLD_W = $bits(pack_l1d_data_ram_evict_req);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [PLD_W-1:0]             fifo_dout_raw;
    pack_l1d_data_ram_evict_req   fifo_dout;
    pack_l1d_data_ram_evict_req   wb_pld;
    logic                         wb_vld;
    logic                         drain;
    logic                         beat_acc;
    logic                         ovf;
    logic                         seq_bad;

    logic [L1D_OFFSET_WIDTH-1:0]  exp_off_q, exp_off_d;
    logic                         credit_ret_q, credit_ret_d;
    logic                         done_vld_q, done_vld_d;
    pack_l1d_evict_done           done_q, done_d;
    logic                         err_ovf_q, err_ovf_d;
    logic                         err_seq_q, err_seq_d;

    assign fifo_dout = fifo_dout_raw;

`ifdef L1D_EVICT_BUF_BYPASS_EN
    assign wb_vld    = !fifo_empty || bus.evict_vld;
    assign wb_pld    = fifo_empty ? bus.evict_pld : fifo_dout;
    // a bypassed beat that is taken immediately never occupies a slot
    assign fifo_push = bus.evict_vld && !(fifo_empty && bus.wb_rdy);
`else
    assign wb_vld    = !fifo_empty;
    assign wb_pld    = fifo_dout;
    assign fifo_push = bus.evict_vld;
`endif

    assign drain    = wb_vld && bus.wb_rdy;
    assign fifo_pop = drain && !fifo_empty;
    assign beat_acc = bus.evict_vld && (!fifo_full || fifo_pop);
    assign ovf      = bus.evict_vld && fifo_full && !fifo_pop;
    assign seq_bad  = bus.evict_vld &&
                      ((bus.evict_pld.offset != exp_off_q) ||
                       (bus.evict_pld.rd_last != is_last_offset(exp_off_q)));

    l1d_evict_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (PLD_W),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (bus.evict_pld),
        .pop   (fifo_pop),
        .dout  (fifo_dout_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        exp_off_d = exp_off_q;
        if (beat_acc) begin
            exp_off_d = bus.evict_pld.rd_last ? '0 : exp_off_q + L1D_OFFSET_WIDTH'(1);
        end
        credit_ret_d = drain;
        done_vld_d   = drain && wb_pld.rd_last;
        done_d       = done_q;
        if (done_vld_d) begin
            done_d.evict_id = wb_pld.evict_id;
        end
        err_ovf_d = err_ovf_q | ovf;
        err_seq_d = err_seq_q | seq_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_off_q    <= '0;
            credit_ret_q <= 1'b0;
            done_vld_q   <= 1'b0;
            done_q       <= '0;
            err_ovf_q    <= 1'b0;
            err_seq_q    <= 1'b0;
        end else begin
            exp_off_q    <= exp_off_d;
            credit_ret_q <= credit_ret_d;
            done_vld_q   <= done_vld_d;
            done_q       <= done_d;
            err_ovf_q    <= err_ovf_d;
            err_seq_q    <= err_seq_d;
        end
    end

    assign bus.wb_vld         = wb_vld;
    assign bus.wb_pld         = wb_pld;
    assign bus.credit_ret     = credit_ret_q;
    assign bus.evict_done_vld = done_vld_q;
    assign bus.evict_done_id  = done_q.evict_id;
    assign bus.err_overflow   = err_ovf_q;
    assign bus.err_seq        = err_seq_q;

endmodule

// File: tb/tb_l1d_evict_buf.sv
// Directed bench for l1d_evict_buf: single line, backpressure, full/overflow, sequence error, mid-line reset.
module tb_l1d_evict_buf;
    import l1d_package::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1d_evict_buf_if bus ();

    l1d_evict_buf #(.BUF_DEPTH(CREDIT_BUF_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cred_cnt;
    pack_l1d_data_ram_evict_req exp_q[$];
    int                         exp_done_q[$];
    pack_l1d_data_ram_evict_req bv[5];

    function automatic pack_l1d_data_ram_evict_req mk(input int off, input bit last, input int id);
        pack_l1d_data_ram_evict_req b;
        b          = '0;
        b.tag      = L1D_TAG_WIDTH'(32'hA000 + id);
        b.index    = L1D_INDEX_WIDTH'(id * 3 + off);
        b.offset   = L1D_OFFSET_WIDTH'(off);
        b.data     = {8{32'(32'h5A00 + id * 256 + off)}};
        b.rd_last  = last;
        b.evict_id = L1D_MSHR_ID_WIDTH'(id);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_pld(input string tag, input pack_l1d_data_ram_evict_req obs,
                           input pack_l1d_data_ram_evict_req exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed id=%0d off=%0d last=%0b data=%0h expected id=%0d off=%0d last=%0b data=%0h",
                    tag, obs.evict_id, obs.offset, obs.rd_last, obs.data[31:0],
                    exp.evict_id, exp.offset, exp.rd_last, exp.data[31:0]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pops everything with wb_rdy=1, checking beat order, done ids and counting credits.
    task automatic drain(input int max_cyc);
        bus.wb_rdy    = 1'b1;
        bus.evict_vld = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.credit_ret) cred_cnt++;
            if (bus.evict_done_vld) begin
                if (exp_done_q.size() == 0) chk("done_extra", 32'(bus.evict_done_vld), 32'd0);
                else chk("done_id", 32'(bus.evict_done_id), 32'(exp_done_q.pop_front()));
            end
            if (bus.wb_vld) begin
                if (exp_q.size() == 0) chk("wb_extra", 32'(bus.wb_vld), 32'd0);
                else chk_pld("wb_pld_order", bus.wb_pld, exp_q.pop_front());
            end
            cyc();
        end
        chk("drain_beats_left", 32'(exp_q.size()), 32'd0);
        chk("drain_done_left", 32'(exp_done_q.size()), 32'd0);
        bus.wb_rdy = 1'b0;
    endtask

    initial begin
        bus.evict_vld = 1'b0;
        bus.evict_pld = '0;
        bus.wb_rdy    = 1'b0;
        rst_n         = 1'b0;
        repeat (3) cyc();

        chk("rst_wb_vld",   32'(bus.wb_vld),         32'd0);
        chk("rst_credit",   32'(bus.credit_ret),     32'd0);
        chk("rst_done_vld", 32'(bus.evict_done_vld), 32'd0);
        chk("rst_done_id",  32'(bus.evict_done_id),  32'd0);
        chk("rst_err_ovf",  32'(bus.err_overflow),   32'd0);
        chk("rst_err_seq",  32'(bus.err_seq),        32'd0);
        rst_n = 1'b1;
        cyc();

`ifndef L1D_EVICT_BUF_BYPASS_EN
        // single line, registered path: one cycle of latency
        bus.wb_rdy    = 1'b1;
        bus.evict_vld = 1'b1;
        bus.evict_pld = mk(0, 0, 5);
        #1;
        chk("sl_wb_vld_c0", 32'(bus.wb_vld), 32'd0);
        cyc();
        chk("sl_wb_vld_c1", 32'(bus.wb_vld), 32'd1);
        chk_pld("sl_pld_c1", bus.wb_pld, mk(0, 0, 5));
        chk("sl_credit_c1", 32'(bus.credit_ret), 32'd0);
        bus.evict_pld = mk(1, 1, 5);
        cyc();
        chk("sl_wb_vld_c2", 32'(bus.wb_vld), 32'd1);
        chk_pld("sl_pld_c2", bus.wb_pld, mk(1, 1, 5));
        chk("sl_credit_c2", 32'(bus.credit_ret), 32'd1);
        chk("sl_done_c2", 32'(bus.evict_done_vld), 32'd0);
        bus.evict_vld = 1'b0;
        cyc();
        chk("sl_wb_vld_c3", 32'(bus.wb_vld), 32'd0);
        chk("sl_credit_c3", 32'(bus.credit_ret), 32'd1);
        chk("sl_done_c3", 32'(bus.evict_done_vld), 32'd1);
        chk("sl_done_id_c3", 32'(bus.evict_done_id), 32'd5);
        cyc();
        chk("sl_credit_c4", 32'(bus.credit_ret), 32'd0);
        chk("sl_done_c4", 32'(bus.evict_done_vld), 32'd0);
        chk("sl_err_seq", 32'(bus.err_seq), 32'd0);
`else
        // bypass: empty buffer forwards the beat in the same cycle
        bus.wb_rdy    = 1'b1;
        bus.evict_vld = 1'b1;
        bus.evict_pld = mk(0, 0, 5);
        #1;
        chk("byp_wb_vld_c0", 32'(bus.wb_vld), 32'd1);
        chk_pld("byp_pld_c0", bus.wb_pld, mk(0, 0, 5));
        cyc();
        bus.evict_pld = mk(1, 1, 5);
        #1;
        chk("byp_credit_c1", 32'(bus.credit_ret), 32'd1);
        chk("byp_wb_vld_c1", 32'(bus.wb_vld), 32'd1);
        chk_pld("byp_pld_c1", bus.wb_pld, mk(1, 1, 5));
        cyc();
        bus.evict_vld = 1'b0;
        #1;
        chk("byp_fifo_empty", 32'(bus.wb_vld), 32'd0);
        chk("byp_credit_c2", 32'(bus.credit_ret), 32'd1);
        chk("byp_done_c2", 32'(bus.evict_done_vld), 32'd1);
        chk("byp_done_id_c2", 32'(bus.evict_done_id), 32'd5);
        cyc();
        chk("byp_credit_c3", 32'(bus.credit_ret), 32'd0);
        chk("byp_err_seq", 32'(bus.err_seq), 32'd0);
`endif

        // backpressure: fill with two lines while wb is stalled
        bv[0] = mk(0, 0, 3);
        bv[1] = mk(1, 1, 3);
        bv[2] = mk(0, 0, 7);
        bv[3] = mk(1, 1, 7);
        bv[4] = mk(0, 0, 9);
        bus.wb_rdy = 1'b0;
        cred_cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            bus.evict_vld = 1'b1;
            bus.evict_pld = bv[i];
            cyc();
            if (bus.credit_ret) cred_cnt++;
        end
        bus.evict_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_wb_vld", 32'(bus.wb_vld), 32'd1);
            chk_pld("bp_pld_hold", bus.wb_pld, bv[0]);
            if (bus.credit_ret) cred_cnt++;
            cyc();
        end
        chk("bp_no_credit", 32'(cred_cnt), 32'd0);
        chk("bp_err_ovf", 32'(bus.err_overflow), 32'd0);

        // full with a simultaneous pop: push accepted
        bus.evict_vld = 1'b1;
        bus.evict_pld = bv[4];
        bus.wb_rdy    = 1'b1;
        cyc();
        chk("fs_ovf_0", 32'(bus.err_overflow), 32'd0);
        chk("fs_credit", 32'(bus.credit_ret), 32'd1);

        // full without a pop: beat dropped
        bus.wb_rdy    = 1'b0;
        bus.evict_pld = mk(1, 1, 9);
        cyc();
        bus.evict_vld = 1'b0;
        chk("fs_ovf_1", 32'(bus.err_overflow), 32'd1);
        chk_pld("fs_head", bus.wb_pld, bv[1]);
        chk("fs_err_seq", 32'(bus.err_seq), 32'd0);

        exp_q      = '{bv[1], bv[2], bv[3], bv[4]};
        exp_done_q = '{3, 7};
        cred_cnt   = 0;
        drain(8);
        chk("bp_credits", 32'(cred_cnt), 32'd4);
        chk("ovf_sticky", 32'(bus.err_overflow), 32'd1);

        // reset in the middle of a line
        bus.evict_vld = 1'b1;
        bus.evict_pld = mk(0, 0, 1);
        cyc();
        bus.evict_vld = 1'b0;
        chk("rm_wb_vld_pre", 32'(bus.wb_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_wb_vld", 32'(bus.wb_vld), 32'd0);
        chk("rm_ovf_clr", 32'(bus.err_overflow), 32'd0);
        cyc();
        rst_n      = 1'b1;
        bus.wb_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rm_no_credit", 32'(bus.credit_ret), 32'd0);
            chk("rm_no_done", 32'(bus.evict_done_vld), 32'd0);
            chk("rm_no_wb", 32'(bus.wb_vld), 32'd0);
        end
        bus.wb_rdy = 1'b0;

        // new line after reset
        bus.evict_vld = 1'b1;
        bus.evict_pld = mk(0, 0, 6);
        cyc();
        bus.evict_pld = mk(1, 1, 6);
        cyc();
        bus.evict_vld = 1'b0;
        exp_q      = '{mk(0, 0, 6), mk(1, 1, 6)};
        exp_done_q = '{6};
        cred_cnt   = 0;
        drain(6);
        chk("rm_line_credits", 32'(cred_cnt), 32'd2);
        chk("rm_line_err_seq", 32'(bus.err_seq), 32'd0);

        // sequence error: line starting at offset 1
        bus.evict_vld = 1'b1;
        bus.evict_pld = mk(1, 1, 2);
        cyc();
        bus.evict_vld = 1'b0;
        chk("se_err_seq", 32'(bus.err_seq), 32'd1);
        exp_q      = '{mk(1, 1, 2)};
        exp_done_q = '{2};
        cred_cnt   = 0;
        drain(4);
        chk("se_credit", 32'(cred_cnt), 32'd1);
        chk("se_err_seq_sticky", 32'(bus.err_seq), 32'd1);
        chk("se_err_ovf", 32'(bus.err_overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
